lif_neuron: RTL and testbench
=============================

// Module: lif_neuron
// PURPOSE
//   Leaky integrate-and-fire neuron; the stage directly downstream of the synapse.
//   Each cycle it integrates the synapse's 8-bit activation into a membrane
//   potential and applies a shift-based leak.
//   When the potential reaches threshold it fires a one-cycle post_spike, which
//   feeds back to the synapse for STDP, then holds the potential at zero for a
//   refractory period.
// PARAMETERS
//   WIDTH           8   membrane/activation width (bits)
//   LEAK_SHIFT      3   leak = v >> LEAK_SHIFT, subtracted every enabled cycle
//   REFRACT_CYCLES  4   cycles of refractory after a spike (0 = none)
// PORTS
//   clk          in   1      single clock, rising edge
//   reset        in   1      synchronous, active-high
//   enable       in   1      1 = advance neuron this cycle; 0 = freeze all state
//   activation   in   [0:7]  unsigned synaptic drive, bit 0 = MSB
//   threshold    in   [0:7]  unsigned firing threshold; 0 = firing disabled
//   post_spike   out  1      registered one-cycle fire pulse
//   membrane     out  [0:7]  current membrane potential, registered
//   refractory   out  1      high while in REFRACT state
// BEHAVIOUR
//   Reset (sync, priority over enable): membrane=0, post_spike=0, refractory=0,
//     state=INTEG, refractory counter=0. Reset mid-refractory aborts refractory.
//   States: INTEG, REFRACT. All updates occur only when enable=1.
//     With enable=0, every register holds, except post_spike, which is forced to 0.
//   INTEG, enable=1:
//     nxt = v - (v>>LEAK_SHIFT) + activation, computed WIDTH+1 bits wide.
//     nxt is saturated to 255; it never wraps.
//     If threshold!=0 and nxt>=threshold: membrane<=0 and post_spike<=1.
//       If REFRACT_CYCLES>0: cnt<=REFRACT_CYCLES and state<=REFRACT.
//       Otherwise the state stays INTEG.
//     Else: membrane<=nxt, post_spike<=0.
//   REFRACT, enable=1: activation ignored, membrane held 0, post_spike<=0, cnt<=cnt-1.
//     When cnt==1 at the edge, state<=INTEG.
//     Integration resumes on the following enabled edge.
//   Latency: activation sampled at edge k appears in membrane after edge k.
//     post_spike is high for the cycle after edge k; membrane reads 0 in that cycle.
//   refractory output = (state==REFRACT), registered.
//   post_spike is never high in two consecutive cycles when REFRACT_CYCLES>0.
//   Threshold changes take effect on the next enabled edge; no internal latching.
// STRUCTURE
//   snn_pkg: WIDTH default, state enum {INTEG, REFRACT}, saturating-add function.
//   Sub-module lif_update (combinational): v, activation, LEAK_SHIFT -> saturated nxt.
//   lif_neuron holds the FSM, refractory counter ($clog2(REFRACT_CYCLES+1) bits),
//     and the output registers.
// TESTING  (LEAK_SHIFT=3, REFRACT_CYCLES=4 unless stated)
//   1 Integrate: thr=100, act=20, enable=1 from reset.
//     -> membrane 20,38,54,68,80,90,99, then post_spike=1 with membrane=0
//        on the 8th edge.
//   2 Saturation: thr=0, act=255. -> membrane 255 and stays 255; post_spike never 1.
//   3 Refractory: thr=100, act=255. -> spike after edge 1; refractory=1 for
//     4 cycles with membrane=0; spike again after edge 6 (period 5).
//   4 Leak: preload v=80 (act=80, thr=0), then act=0.
//     -> membrane 70,62,55,49,...; it decays to a floor of 7, because
//        7>>3 = 0, and never goes negative.
//   5 Enable gating: mid-scenario 1, drop enable for 3 cycles.
//     -> membrane/state frozen and post_spike=0; the sequence resumes exactly
//        where it stopped.
//   6 Reset mid-refractory: assert reset during the 2nd refractory cycle.
//     -> next edge: membrane=0, refractory=0, post_spike=0, state INTEG;
//        integration restarts from 0.
//   Also: REFRACT_CYCLES=0 build with thr=100, act=255 -> post_spike high every cycle.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath.
//   WIDTH       default membrane/activation width
//   lif_state_e neuron FSM states (INTEG integrates, REFRACT holds at zero)
//   sat_add     unsigned add clamped to a caller-supplied ceiling
package snn_pkg;

  localparam int WIDTH = 8;

  typedef enum logic {
    INTEG   = 1'b0,
    REFRACT = 1'b1
  } lif_state_e;

  // Operands are widened to 32 bits by the caller, so the raw sum cannot
  // overflow for any WIDTH below 31 and the clamp alone is enough.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_v);
    int unsigned s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational membrane update for the LIF neuron.
//   v_i    current membrane potential
//   act_i  synaptic activation to integrate
//   nxt_o  v - (v >> LEAK_SHIFT) + act, clamped to the all-ones value
module lif_update
  import snn_pkg::*;
#(
  parameter int WIDTH      = snn_pkg::WIDTH,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] act_i,
  output logic [WIDTH-1:0] nxt_o
);

  localparam int unsigned MAX_V = (2 ** WIDTH) - 1;

  logic [WIDTH-1:0] leaked;

  // The leak term is at most v itself, so this subtraction cannot underflow;
  // small potentials (below 2**LEAK_SHIFT) simply stop decaying.
  assign leaked = v_i - (v_i >> LEAK_SHIFT);

  assign nxt_o = WIDTH'(sat_add(32'(leaked), 32'(act_i), MAX_V));

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with refractory hold.
//   clk         rising-edge clock
//   reset       synchronous active-high reset, overrides enable
//   enable      advances the neuron; when low all state holds and post_spike is 0
//   activation  synaptic drive (bit 0 = MSB)
//   threshold   firing threshold (bit 0 = MSB), 0 disables firing
//   post_spike  registered one-cycle fire pulse
//   membrane    registered membrane potential (bit 0 = MSB)
//   refractory  high while the neuron is in its refractory hold
module lif_neuron
  import snn_pkg::*;
#(
  parameter int WIDTH          = snn_pkg::WIDTH,
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [0:WIDTH-1] activation,
  input  logic [0:WIDTH-1] threshold,
  output logic             post_spike,
  output logic [0:WIDTH-1] membrane,
  output logic             refractory
);

  // A zero-cycle build still needs a legal one-bit counter.
  localparam int CNT_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  lif_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] membrane_q, membrane_d;
  logic             spike_q, spike_d;

  // Descending copies so all arithmetic uses conventional MSB-left vectors;
  // bit 0 of the ascending ports is still the MSB, so values are unchanged.
  logic [WIDTH-1:0] act_w, thr_w, nxt_w;
  assign act_w = activation;
  assign thr_w = threshold;

  lif_update #(
    .WIDTH     (WIDTH),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_update (
    .v_i  (membrane_q),
    .act_i(act_w),
    .nxt_o(nxt_w)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    membrane_d = membrane_q;
    spike_d    = 1'b0;
    if (enable) begin
      unique case (state_q)
        INTEG: begin
          if ((thr_w != '0) && (nxt_w >= thr_w)) begin
            membrane_d = '0;
            spike_d    = 1'b1;
            if (REFRACT_CYCLES > 0) begin
              cnt_d   = CNT_W'(REFRACT_CYCLES);
              state_d = REFRACT;
            end
          end else begin
            membrane_d = nxt_w;
          end
        end
        REFRACT: begin
          // Activation is ignored; the last counted edge returns to INTEG so
          // integration resumes on the next enabled edge.
          membrane_d = '0;
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = INTEG;
          end
        end
        default: state_d = INTEG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INTEG;
      cnt_q      <= '0;
      membrane_q <= '0;
      spike_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      membrane_q <= membrane_d;
      spike_q    <= spike_d;
    end
  end

  assign post_spike = spike_q;
  assign membrane   = membrane_q;
  assign refractory = (state_q == REFRACT);

endmodule

// File: tb/tb_lif_neuron.sv
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [0:7] activation;
  logic [0:7] threshold;
  logic       post_spike, refractory;
  logic [0:7] membrane;
  logic       post_spike0, refractory0;
  logic [0:7] membrane0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lif_neuron #(.WIDTH(8), .LEAK_SHIFT(3), .REFRACT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .activation(activation),
    .threshold (threshold),
    .post_spike(post_spike),
    .membrane  (membrane),
    .refractory(refractory)
  );

  lif_neuron #(.WIDTH(8), .LEAK_SHIFT(3), .REFRACT_CYCLES(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .activation(activation),
    .threshold (threshold),
    .post_spike(post_spike0),
    .membrane  (membrane0),
    .refractory(refractory0)
  );

  // Advance one edge and sample 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    $display("%s rst=%0d en=%0d act=%0d thr=%0d -> mem=%0d spike=%0d refr=%0d",
             tag, reset, enable, activation, threshold, membrane, post_spike, refractory);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; activation = 8'd0; threshold = 8'd0;
    step("reset");
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // Reset while enable is low: reset must still win.
    reset = 1'b1; enable = 1'b0; activation = 8'd200; threshold = 8'd100;
    step("test_reset");
    checks++;
    if (membrane !== 8'd0 || post_spike !== 1'b0 || refractory !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mem=%0d spike=%0d refr=%0d, required 0/0/0",
               membrane, post_spike, refractory);
    end
    reset = 1'b0;
  endtask

  task automatic test_integrate();
    int exp_mem[7] = '{20, 38, 54, 68, 80, 90, 99};
    do_reset();
    enable = 1'b1; activation = 8'd20; threshold = 8'd100;
    for (int i = 0; i < 7; i++) begin
      step("integrate");
      checks++;
      if (membrane !== 8'(exp_mem[i]) || post_spike !== 1'b0) begin
        errors++;
        $display("FAIL integrate[%0d]: mem=%0d spike=%0d, required mem=%0d spike=0",
                 i, membrane, post_spike, exp_mem[i]);
      end
    end
    step("integrate");
    checks++;
    if (membrane !== 8'd0 || post_spike !== 1'b1 || refractory !== 1'b1) begin
      errors++;
      $display("FAIL integrate_fire: mem=%0d spike=%0d refr=%0d, required 0/1/1",
               membrane, post_spike, refractory);
    end
    step("integrate");
    checks++;
    if (post_spike !== 1'b0) begin
      errors++;
      $display("FAIL integrate_pulse_width: spike=%0d, required 0", post_spike);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    enable = 1'b1; activation = 8'd255; threshold = 8'd0;
    for (int i = 0; i < 5; i++) begin
      step("saturation");
      checks++;
      if (membrane !== 8'd255 || post_spike !== 1'b0) begin
        errors++;
        $display("FAIL saturation[%0d]: mem=%0d spike=%0d, required mem=255 spike=0",
                 i, membrane, post_spike);
      end
    end
  endtask

  task automatic test_refractory();
    // Edges 1..11: spikes at 1,6,11; refractory after edges 1-4 and 6-9 and 11.
    logic exp_spk[11] = '{1,0,0,0,0,1,0,0,0,0,1};
    logic exp_ref[11] = '{1,1,1,1,0,1,1,1,1,0,1};
    do_reset();
    enable = 1'b1; activation = 8'd255; threshold = 8'd100;
    for (int i = 0; i < 11; i++) begin
      step("refractory");
      checks++;
      if (post_spike !== exp_spk[i] || refractory !== exp_ref[i] || membrane !== 8'd0) begin
        errors++;
        $display("FAIL refractory[edge %0d]: spike=%0d refr=%0d mem=%0d, required spike=%0d refr=%0d mem=0",
                 i + 1, post_spike, refractory, membrane, exp_spk[i], exp_ref[i]);
      end
    end
  endtask

  task automatic test_leak();
    int exp_mem[23] = '{70, 62, 55, 49, 43, 38, 34, 30, 27, 24, 21, 19,
                        17, 15, 14, 13, 12, 11, 10, 9, 8, 7, 7};
    do_reset();
    enable = 1'b1; activation = 8'd80; threshold = 8'd0;
    step("leak_preload");
    checks++;
    if (membrane !== 8'd80) begin
      errors++;
      $display("FAIL leak_preload: mem=%0d, required 80", membrane);
    end
    activation = 8'd0;
    for (int i = 0; i < 23; i++) begin
      step("leak");
      checks++;
      if (membrane !== 8'(exp_mem[i])) begin
        errors++;
        $display("FAIL leak[%0d]: mem=%0d, required %0d", i, membrane, exp_mem[i]);
      end
    end
  endtask

  task automatic test_enable();
    int exp_mem[4] = '{68, 80, 90, 99};
    do_reset();
    enable = 1'b1; activation = 8'd20; threshold = 8'd100;
    step("enable"); step("enable"); step("enable");   // 20, 38, 54
    enable = 1'b0; activation = 8'd200;
    for (int i = 0; i < 3; i++) begin
      step("enable_frozen");
      checks++;
      if (membrane !== 8'd54 || post_spike !== 1'b0 || refractory !== 1'b0) begin
        errors++;
        $display("FAIL enable_frozen[%0d]: mem=%0d spike=%0d refr=%0d, required 54/0/0",
                 i, membrane, post_spike, refractory);
      end
    end
    enable = 1'b1; activation = 8'd20;
    for (int i = 0; i < 4; i++) begin
      step("enable_resume");
      checks++;
      if (membrane !== 8'(exp_mem[i])) begin
        errors++;
        $display("FAIL enable_resume[%0d]: mem=%0d, required %0d", i, membrane, exp_mem[i]);
      end
    end
    step("enable_fire");
    checks++;
    if (post_spike !== 1'b1 || membrane !== 8'd0) begin
      errors++;
      $display("FAIL enable_fire: spike=%0d mem=%0d, required 1/0", post_spike, membrane);
    end
    // Disabling right after a spike kills the pulse but keeps refractory state.
    enable = 1'b0;
    step("enable_spike_gate");
    checks++;
    if (post_spike !== 1'b0 || refractory !== 1'b1 || membrane !== 8'd0) begin
      errors++;
      $display("FAIL enable_spike_gate: spike=%0d refr=%0d mem=%0d, required 0/1/0",
               post_spike, refractory, membrane);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("enable_refract");
      checks++;
      if (refractory !== (i < 3)) begin
        errors++;
        $display("FAIL enable_refract[%0d]: refr=%0d, required %0d", i, refractory, (i < 3));
      end
    end
  endtask

  task automatic test_reset_mid_refract();
    do_reset();
    enable = 1'b1; activation = 8'd255; threshold = 8'd100;
    step("midref");          // spike, first refractory cycle
    step("midref");          // second refractory cycle
    checks++;
    if (refractory !== 1'b1) begin
      errors++;
      $display("FAIL midref_setup: refr=%0d, required 1", refractory);
    end
    reset = 1'b1;
    step("midref_reset");
    checks++;
    if (membrane !== 8'd0 || refractory !== 1'b0 || post_spike !== 1'b0) begin
      errors++;
      $display("FAIL midref_reset: mem=%0d refr=%0d spike=%0d, required 0/0/0",
               membrane, refractory, post_spike);
    end
    reset = 1'b0; activation = 8'd20;
    step("midref_restart");
    checks++;
    if (membrane !== 8'd20 || refractory !== 1'b0) begin
      errors++;
      $display("FAIL midref_restart: mem=%0d refr=%0d, required 20/0", membrane, refractory);
    end
  endtask

  task automatic test_threshold_boundary();
    do_reset();
    enable = 1'b1; activation = 8'd20; threshold = 8'd21;
    step("thr_below");
    checks++;
    if (post_spike !== 1'b0 || membrane !== 8'd20) begin
      errors++;
      $display("FAIL thr_below: spike=%0d mem=%0d, required 0/20", post_spike, membrane);
    end
    do_reset();
    enable = 1'b1; activation = 8'd20; threshold = 8'd20;
    step("thr_equal");
    checks++;
    if (post_spike !== 1'b1 || membrane !== 8'd0) begin
      errors++;
      $display("FAIL thr_equal: spike=%0d mem=%0d, required 1/0", post_spike, membrane);
    end
  endtask

  task automatic test_no_refract();
    do_reset();
    enable = 1'b1; activation = 8'd255; threshold = 8'd100;
    for (int i = 0; i < 4; i++) begin
      step("no_refract");
      checks++;
      if (post_spike0 !== 1'b1 || membrane0 !== 8'd0 || refractory0 !== 1'b0) begin
        errors++;
        $display("FAIL no_refract[%0d]: spike=%0d mem=%0d refr=%0d, required 1/0/0",
                 i, post_spike0, membrane0, refractory0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; activation = 8'd0; threshold = 8'd0;
    test_reset();
    test_integrate();
    test_saturation();
    test_refractory();
    test_leak();
    test_enable();
    test_reset_mid_refract();
    test_threshold_boundary();
    test_no_refract();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
